// File: rtl/phj_pkg.sv
// Shared hash-join definitions: phase encoding and tuple/hash/serial widths.
package phj_pkg;

  localparam int TUPLE_W  = 64;
  localparam int HASH_W   = 32;
  localparam int SERIAL_W = 64;

  typedef enum logic [2:0] {
    PH_IDLE        = 3'd0,
    PH_BUILD       = 3'd1,
    PH_BUILD_DRAIN = 3'd2,
    PH_PROBE       = 3'd3,
    PH_PROBE_WAIT  = 3'd4,
    PH_DONE        = 3'd5
  } phase_e;

endpackage

// File: rtl/hash_join_phase_ctrl.sv
// Sequences one hash join: build pass-through, table settle, probe pass-through,
// then waits for the last hash-table result while keeping run statistics.
module hash_join_phase_ctrl
  import phj_pkg::*;
#(
  parameter int DRAIN_CYCLES = 8,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [2:0]          phase,

  input  logic                s_build_valid,
  output logic                s_build_ready,
  input  logic [TUPLE_W-1:0]  s_build_data,
  input  logic [HASH_W-1:0]   s_build_hash,
  input  logic                s_build_last,

  input  logic                s_probe_valid,
  output logic                s_probe_ready,
  input  logic [TUPLE_W-1:0]  s_probe_data,
  input  logic [HASH_W-1:0]   s_probe_hash,
  input  logic                s_probe_last,

  output logic                ht_build_valid,
  input  logic                ht_build_ready,
  output logic [TUPLE_W-1:0]  ht_build_data,
  output logic [HASH_W-1:0]   ht_build_hash,
  output logic                ht_build_last,

  output logic                ht_probe_valid,
  input  logic                ht_probe_ready,
  output logic [TUPLE_W-1:0]  ht_probe_data,
  output logic [HASH_W-1:0]   ht_probe_hash,
  output logic                ht_probe_last,
  output logic [SERIAL_W-1:0] ht_serialnum,

  input  logic                ht_out_valid,
  input  logic                ht_out_ready,
  input  logic                ht_out_last,
  input  logic                ht_out_joined,

  output logic [CNT_W-1:0]    build_count,
  output logic [CNT_W-1:0]    probe_count,
  output logic [CNT_W-1:0]    match_count
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       DRAIN_LD  = 8'(DRAIN_CYCLES);

  phase_e           state_r, state_s;
  logic [7:0]       drain_r, drain_s;
  logic [CNT_W-1:0] build_count_r, probe_count_r, match_count_r;

  logic in_build_s, in_probe_s, build_fire_s, probe_fire_s;
  logic out_fire_s, match_s, launch_s;

  assign in_build_s   = (state_r == PH_BUILD);
  assign in_probe_s   = (state_r == PH_PROBE);
  assign build_fire_s = in_build_s & s_build_valid & ht_build_ready;
  assign probe_fire_s = in_probe_s & s_probe_valid & ht_probe_ready;
  assign out_fire_s   = ht_out_valid & ht_out_ready;
  assign match_s      = out_fire_s & ht_out_joined &
                        ((state_r == PH_PROBE) | (state_r == PH_PROBE_WAIT));
  assign launch_s     = start & ((state_r == PH_IDLE) | (state_r == PH_DONE));

  // Zero-latency stream gating: each stream only flows in its own phase.
  assign ht_build_valid = in_build_s & s_build_valid;
  assign s_build_ready  = in_build_s & ht_build_ready;
  assign ht_build_data  = s_build_data;
  assign ht_build_hash  = s_build_hash;
  assign ht_build_last  = s_build_last;

  assign ht_probe_valid = in_probe_s & s_probe_valid;
  assign s_probe_ready  = in_probe_s & ht_probe_ready;
  assign ht_probe_data  = s_probe_data;
  assign ht_probe_hash  = s_probe_hash;
  assign ht_probe_last  = s_probe_last;
  assign ht_serialnum   = SERIAL_W'(probe_count_r);

  assign phase       = state_r;
  assign busy        = (state_r != PH_IDLE) & (state_r != PH_DONE);
  assign done        = (state_r == PH_DONE);
  assign build_count = build_count_r;
  assign probe_count = probe_count_r;
  assign match_count = match_count_r;

  // Phase state and settle down-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= PH_IDLE;
      drain_r <= 8'd0;
    end else begin
      state_r <= state_s;
      drain_r <= drain_s;
    end
  end

  // Next-phase decode; the drain counter is loaded when the last build beat lands.
  always_comb begin
    state_s = state_r;
    drain_s = drain_r;
    case (state_r)
      PH_IDLE, PH_DONE: begin
        if (start) state_s = PH_BUILD;
        else       state_s = state_r;
      end
      PH_BUILD: begin
        if (build_fire_s && s_build_last) begin
          state_s = PH_BUILD_DRAIN;
          drain_s = DRAIN_LD;
        end else begin
          state_s = PH_BUILD;
        end
      end
      PH_BUILD_DRAIN: begin
        if (drain_r <= 8'd1) begin
          state_s = PH_PROBE;
          drain_s = 8'd0;
        end else begin
          drain_s = drain_r - 8'd1;
        end
      end
      PH_PROBE: begin
        if (probe_fire_s && s_probe_last) state_s = PH_PROBE_WAIT;
        else                              state_s = PH_PROBE;
      end
      PH_PROBE_WAIT: begin
        if (out_fire_s && ht_out_last) state_s = PH_DONE;
        else                           state_s = PH_PROBE_WAIT;
      end
      default: begin
        state_s = PH_IDLE;
        drain_s = 8'd0;
      end
    endcase
  end

  // Saturating run statistics, cleared when a new run is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      build_count_r <= '0;
      probe_count_r <= '0;
      match_count_r <= '0;
    end else if (launch_s) begin
      build_count_r <= '0;
      probe_count_r <= '0;
      match_count_r <= '0;
    end else begin
      if (build_fire_s && (build_count_r != CNT_MAX))
        build_count_r <= build_count_r + CNT_ONE;
      if (probe_fire_s && (probe_count_r != CNT_MAX))
        probe_count_r <= probe_count_r + CNT_ONE;
      if (match_s && (match_count_r != CNT_MAX))
        match_count_r <= match_count_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hash_join_phase_ctrl.sv
// Directed bench for hash_join_phase_ctrl: a phase-level reference model is
// compared every cycle, plus hand-computed spot checks and a narrow-counter instance.
module tb_hash_join_phase_ctrl;
  import phj_pkg::*;

  localparam int     DRAIN = 8;
  localparam longint MAXV  = (64'sd1 <<< 32) - 64'sd1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        s_build_valid, s_build_last, s_probe_valid, s_probe_last;
  logic [63:0] s_build_data, s_probe_data;
  logic [31:0] s_build_hash, s_probe_hash;
  logic        ht_build_ready, ht_probe_ready;
  logic        ht_out_valid, ht_out_ready, ht_out_last, ht_out_joined;

  logic        busy, done, s_build_ready, s_probe_ready;
  logic [2:0]  phase;
  logic        ht_build_valid, ht_build_last, ht_probe_valid, ht_probe_last;
  logic [63:0] ht_build_data, ht_probe_data, ht_serialnum;
  logic [31:0] ht_build_hash, ht_probe_hash;
  logic [31:0] build_count, probe_count, match_count;

  logic        busy4, done4, s_build_ready4, s_probe_ready4;
  logic [2:0]  phase4;
  logic        ht_build_valid4, ht_build_last4, ht_probe_valid4, ht_probe_last4;
  logic [63:0] ht_build_data4, ht_probe_data4, ht_serialnum4;
  logic [31:0] ht_build_hash4, ht_probe_hash4;
  logic [3:0]  build_count4, probe_count4, match_count4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hash_join_phase_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .phase(phase),
    .s_build_valid(s_build_valid), .s_build_ready(s_build_ready), .s_build_data(s_build_data),
    .s_build_hash(s_build_hash), .s_build_last(s_build_last),
    .s_probe_valid(s_probe_valid), .s_probe_ready(s_probe_ready), .s_probe_data(s_probe_data),
    .s_probe_hash(s_probe_hash), .s_probe_last(s_probe_last),
    .ht_build_valid(ht_build_valid), .ht_build_ready(ht_build_ready), .ht_build_data(ht_build_data),
    .ht_build_hash(ht_build_hash), .ht_build_last(ht_build_last),
    .ht_probe_valid(ht_probe_valid), .ht_probe_ready(ht_probe_ready), .ht_probe_data(ht_probe_data),
    .ht_probe_hash(ht_probe_hash), .ht_probe_last(ht_probe_last), .ht_serialnum(ht_serialnum),
    .ht_out_valid(ht_out_valid), .ht_out_ready(ht_out_ready), .ht_out_last(ht_out_last),
    .ht_out_joined(ht_out_joined),
    .build_count(build_count), .probe_count(probe_count), .match_count(match_count)
  );

  hash_join_phase_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .busy(busy4), .done(done4), .phase(phase4),
    .s_build_valid(s_build_valid), .s_build_ready(s_build_ready4), .s_build_data(s_build_data),
    .s_build_hash(s_build_hash), .s_build_last(s_build_last),
    .s_probe_valid(s_probe_valid), .s_probe_ready(s_probe_ready4), .s_probe_data(s_probe_data),
    .s_probe_hash(s_probe_hash), .s_probe_last(s_probe_last),
    .ht_build_valid(ht_build_valid4), .ht_build_ready(ht_build_ready), .ht_build_data(ht_build_data4),
    .ht_build_hash(ht_build_hash4), .ht_build_last(ht_build_last4),
    .ht_probe_valid(ht_probe_valid4), .ht_probe_ready(ht_probe_ready), .ht_probe_data(ht_probe_data4),
    .ht_probe_hash(ht_probe_hash4), .ht_probe_last(ht_probe_last4), .ht_serialnum(ht_serialnum4),
    .ht_out_valid(ht_out_valid), .ht_out_ready(ht_out_ready), .ht_out_last(ht_out_last),
    .ht_out_joined(ht_out_joined),
    .build_count(build_count4), .probe_count(probe_count4), .match_count(match_count4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Reference model: which phase a run is in, how many settle cycles remain, and the tallies.
  phase_e m_ph;
  int     m_left;
  longint m_bc, m_pc, m_mc;

  // Model update on the same edge as the design; reset is honoured immediately.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= PH_IDLE; m_left <= 0; m_bc <= 0; m_pc <= 0; m_mc <= 0;
    end else begin
      case (m_ph)
        PH_IDLE, PH_DONE:
          if (start) begin
            m_ph <= PH_BUILD; m_bc <= 0; m_pc <= 0; m_mc <= 0;
          end
        PH_BUILD:
          if (s_build_valid && ht_build_ready) begin
            m_bc <= sat(m_bc + 1);
            if (s_build_last) begin m_ph <= PH_BUILD_DRAIN; m_left <= DRAIN; end
          end
        PH_BUILD_DRAIN: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_ph <= PH_PROBE;
        end
        PH_PROBE: begin
          if (s_probe_valid && ht_probe_ready) begin
            m_pc <= sat(m_pc + 1);
            if (s_probe_last) m_ph <= PH_PROBE_WAIT;
          end
          if (ht_out_valid && ht_out_ready && ht_out_joined) m_mc <= sat(m_mc + 1);
        end
        PH_PROBE_WAIT: begin
          if (ht_out_valid && ht_out_ready && ht_out_joined) m_mc <= sat(m_mc + 1);
          if (ht_out_valid && ht_out_ready && ht_out_last) m_ph <= PH_DONE;
        end
        default: m_ph <= PH_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    chk("phase", 64'(phase), 64'(m_ph));
    chk("busy", 64'(busy), 64'(m_ph != PH_IDLE && m_ph != PH_DONE));
    chk("done", 64'(done), 64'(m_ph == PH_DONE));
    chk("build_count", 64'(build_count), 64'(m_bc));
    chk("probe_count", 64'(probe_count), 64'(m_pc));
    chk("match_count", 64'(match_count), 64'(m_mc));
    chk("serialnum", ht_serialnum, 64'(m_pc));
    chk("s_build_ready", 64'(s_build_ready), 64'(m_ph == PH_BUILD && ht_build_ready));
    chk("ht_build_valid", 64'(ht_build_valid), 64'(m_ph == PH_BUILD && s_build_valid));
    chk("s_probe_ready", 64'(s_probe_ready), 64'(m_ph == PH_PROBE && ht_probe_ready));
    chk("ht_probe_valid", 64'(ht_probe_valid), 64'(m_ph == PH_PROBE && s_probe_valid));
    if (m_ph == PH_BUILD) chk("ht_build_data", ht_build_data, s_build_data);
    if (m_ph == PH_PROBE) chk("ht_probe_hash", 64'(ht_probe_hash), 64'(s_probe_hash));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    while (phase == 3'(PH_BUILD_DRAIN) && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic build_beat(input logic [63:0] d, input logic last);
    s_build_valid = 1'b1; s_build_data = d; s_build_hash = d[31:0] ^ 32'h5a5a_0000;
    s_build_last = last;
    step();
    s_build_valid = 1'b0; s_build_last = 1'b0;
  endtask

  task automatic probe_beat(input logic [63:0] d, input logic last);
    s_probe_valid = 1'b1; s_probe_data = d; s_probe_hash = d[31:0] ^ 32'h0000_a5a5;
    s_probe_last = last;
    step();
    s_probe_valid = 1'b0; s_probe_last = 1'b0;
  endtask

  task automatic result(input logic joined, input logic last);
    ht_out_valid = 1'b1; ht_out_joined = joined; ht_out_last = last;
    step();
    ht_out_valid = 1'b0; ht_out_joined = 1'b0; ht_out_last = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0;
    s_build_valid = 1'b0; s_build_last = 1'b0; s_build_data = 64'd0; s_build_hash = 32'd0;
    s_probe_valid = 1'b0; s_probe_last = 1'b0; s_probe_data = 64'd0; s_probe_hash = 32'd0;
    ht_build_ready = 1'b1; ht_probe_ready = 1'b1;
    ht_out_valid = 1'b0; ht_out_ready = 1'b1; ht_out_last = 1'b0; ht_out_joined = 1'b0;
    repeat (2) step();
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();

    // Run 1: four build beats with a stray probe offer, settle, three probes, two matches.
    start = 1'b1; step(); start = 1'b0;
    chk("enter_build", 64'(phase), 64'd1);
    for (int i = 0; i < 4; i++) begin
      s_probe_valid = (i == 0);
      #1;
      if (i == 0) chk("probe_blocked", 64'(s_probe_ready), 64'd0);
      build_beat(64'h1000 + 64'(i), (i == 3));
    end
    s_probe_valid = 1'b0;
    chk("build4", 64'(build_count), 64'd4);
    chk("probe0", 64'(probe_count), 64'd0);
    chk("drain_entry", 64'(phase), 64'd2);
    wait_drain(n);
    chk("drain_len", 64'(n), 64'd8);
    chk("probe_phase", 64'(phase), 64'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("serial", ht_serialnum, 64'(i));
      probe_beat(64'h2000 + 64'(i), (i == 2));
    end
    chk("probe_wait", 64'(phase), 64'd4);
    result(1'b1, 1'b0);
    result(1'b1, 1'b0);
    result(1'b0, 1'b1);
    chk("match2", 64'(match_count), 64'd2);
    chk("done1", 64'(done), 64'd1);

    // Run 2: last build beat stalled, start ignored mid-probe, then reset mid-probe.
    start = 1'b1; step(); start = 1'b0;
    chk("restart_clear", 64'(build_count), 64'd0);
    build_beat(64'h3000, 1'b0);
    build_beat(64'h3001, 1'b0);
    ht_build_ready = 1'b0;
    s_build_valid = 1'b1; s_build_data = 64'h3002; s_build_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_build", 64'(phase), 64'd1);
    end
    chk("stall_count", 64'(build_count), 64'd2);
    ht_build_ready = 1'b1;
    step();
    s_build_valid = 1'b0; s_build_last = 1'b0;
    chk("stall_accept", 64'(phase), 64'd2);
    chk("build3", 64'(build_count), 64'd3);
    wait_drain(n);
    chk("drain_len2", 64'(n), 64'd8);
    probe_beat(64'h4000, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk("start_ignored", 64'(phase), 64'd3);
    chk("probe1", 64'(probe_count), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_phase", 64'(phase), 64'd0);
    chk("rst_mid_counts", 64'(build_count | probe_count | match_count), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("abandoned", 64'(phase), 64'd0);

    // Run 3: twenty build beats saturate the 4-bit counter instance.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) build_beat(64'h5000 + 64'(i), (i == 19));
    chk("sat4", 64'(build_count4), 64'd15);
    chk("build20", 64'(build_count), 64'd20);
    wait_drain(n);
    probe_beat(64'h6000, 1'b1);
    result(1'b1, 1'b1);
    chk("joined_last", 64'(match_count), 64'd1);
    chk("done3", 64'(done), 64'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
